// File: rtl/ski_heap_pkg.sv
// ski_heap_pkg: definitions shared by the SKI reducer, the host term loader
// and the heap arbiter.
//   ADDR_W   - heap address width
//   DATA_W   - heap cell width (tag + two pointers)
//   cell_t   - packed layout of one heap cell
//   req_id_e - identity of a heap requester
package ski_heap_pkg;

    localparam int ADDR_W = 16;
    localparam int PTR_W  = 16;
    localparam int DATA_W = 33;

    // One combinator heap cell: a tag bit and the left/right child pointers.
    typedef struct packed {
        logic             tag;
        logic [PTR_W-1:0] left;
        logic [PTR_W-1:0] right;
    } cell_t;

    // Requester identity, also used to steer read responses.
    typedef enum logic {
        REDUCER = 1'b0,
        LOADER  = 1'b1
    } req_id_e;

endpackage

// File: rtl/ski_heap_arbiter.sv
// ski_heap_arbiter: shares the single-port heap RAM between the SKI reducer
// (requester 0) and the host term loader (requester 1). One access per cycle,
// weighted round-robin favouring the reducer, read data steered back to the
// issuing requester one cycle after the transfer.
// Ports:
//   system1000 / system1000_rst   clock, async active-high reset
//   rN_valid/ready/we/addr/wdata  request channel of requester N
//   r0_lock                       reducer holds the grant for an atomic RMW
//   rN_rsp_valid/rsp_data         read response of requester N
//   ram_en/we/addr/wdata/rdata    single-port heap RAM interface
module ski_heap_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 33,
    parameter int WEIGHT = 4
) (
    input  logic              system1000,
    input  logic              system1000_rst,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic              r0_we,
    input  logic              r0_lock,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_rsp_valid,
    output logic [DATA_W-1:0] r0_rsp_data,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_rsp_valid,
    output logic [DATA_W-1:0] r1_rsp_data,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    import ski_heap_pkg::*;

    localparam logic [3:0] WEIGHT_C = 4'(WEIGHT);

    logic       gnt0_s;
    logic       gnt1_s;
    logic       rd_xfer_s;
    logic [3:0] credit_q;
    logic [3:0] credit_d;
    logic       pend_q;
    logic       pend_d;
    req_id_e    owner_q;
    req_id_e    owner_d;

    // Grant decision: lock or spare credit keeps r0 ahead; reset blocks all transfers.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (system1000_rst) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (r0_valid && (!r1_valid || r0_lock || (credit_q < WEIGHT_C))) begin
            gnt0_s = 1'b1;
        end else if (r1_valid) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    assign r0_ready = gnt0_s;
    assign r1_ready = gnt1_s;

    // RAM port mux: steer the granted requester onto the heap RAM.
    always_comb begin
        ram_en    = gnt0_s | gnt1_s;
        ram_we    = 1'b0;
        ram_addr  = r0_addr;
        ram_wdata = r0_wdata;
        if (gnt1_s) begin
            ram_we    = r1_we;
            ram_addr  = r1_addr;
            ram_wdata = r1_wdata;
        end else if (gnt0_s) begin
            ram_we    = r0_we;
        end else begin
            ram_we    = 1'b0;
        end
    end

    // Credit next state: counts reducer wins while the loader waits, saturating at WEIGHT.
    always_comb begin
        credit_d = credit_q;
        if (!r1_valid || gnt1_s) begin
            credit_d = 4'd0;
        end else if (gnt0_s && (credit_q < WEIGHT_C)) begin
            credit_d = credit_q + 4'd1;
        end else begin
            credit_d = credit_q;
        end
    end

    assign rd_xfer_s = (gnt0_s & ~r0_we) | (gnt1_s & ~r1_we);

    // Response pipeline next state: remember who issued this cycle's read.
    always_comb begin
        pend_d  = rd_xfer_s;
        owner_d = owner_q;
        if (gnt1_s) begin
            owner_d = LOADER;
        end else if (gnt0_s) begin
            owner_d = REDUCER;
        end else begin
            owner_d = owner_q;
        end
    end

    // State registers; async reset also drops any in-flight read response.
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            credit_q <= 4'd0;
            pend_q   <= 1'b0;
            owner_q  <= REDUCER;
        end else begin
            credit_q <= credit_d;
            pend_q   <= pend_d;
            owner_q  <= owner_d;
        end
    end

    // Only the valid strobe is steered; data fans out to both requesters.
    assign r0_rsp_valid = pend_q & (owner_q == REDUCER);
    assign r1_rsp_valid = pend_q & (owner_q == LOADER);
    assign r0_rsp_data  = ram_rdata;
    assign r1_rsp_data  = ram_rdata;

endmodule

// File: tb/tb_ski_heap_arbiter.sv
// Self-checking bench for ski_heap_arbiter: a table of per-cycle arbitration
// vectors plus hand-written multi-cycle sequences, against a small write-first
// RAM model living in the bench.
module tb_ski_heap_arbiter;

    logic        clk;
    logic        rst;
    logic        r0_valid, r0_ready, r0_we, r0_lock, r0_rsp_valid;
    logic [15:0] r0_addr;
    logic [32:0] r0_wdata, r0_rsp_data;
    logic        r1_valid, r1_ready, r1_we, r1_rsp_valid;
    logic [15:0] r1_addr;
    logic [32:0] r1_wdata, r1_rsp_data;
    logic        ram_en, ram_we;
    logic [15:0] ram_addr;
    logic [32:0] ram_wdata, ram_rdata;
    logic [32:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic v0;
        logic l0;
        logic v1;
        logic e0;
        logic e1;
    } vec_t;

    vec_t tbl [$];

    ski_heap_arbiter #(.ADDR_W(16), .DATA_W(33), .WEIGHT(4)) dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .r0_valid       (r0_valid),
        .r0_ready       (r0_ready),
        .r0_we          (r0_we),
        .r0_lock        (r0_lock),
        .r0_addr        (r0_addr),
        .r0_wdata       (r0_wdata),
        .r0_rsp_valid   (r0_rsp_valid),
        .r0_rsp_data    (r0_rsp_data),
        .r1_valid       (r1_valid),
        .r1_ready       (r1_ready),
        .r1_we          (r1_we),
        .r1_addr        (r1_addr),
        .r1_wdata       (r1_wdata),
        .r1_rsp_valid   (r1_rsp_valid),
        .r1_rsp_data    (r1_rsp_data),
        .ram_en         (ram_en),
        .ram_we         (ram_we),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [32:0] init_val(input logic [7:0] a);
        if (a == 8'h10) return 33'h1_2345_6789;
        return {1'b0, 8'hAB, 8'hCD, 8'h00, a};
    endfunction

    // Write-first single-port heap RAM model, reloaded while reset is high.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
        end else if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr[7:0]] <= ram_wdata;
                ram_rdata          <= ram_wdata;
            end else begin
                ram_rdata <= mem[ram_addr[7:0]];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        r0_valid = 1'b0; r0_lock = 1'b0; r0_we = 1'b0;
        r1_valid = 1'b0; r1_we = 1'b0;
    endtask

    task automatic add(input logic v0, input logic l0, input logic v1,
                       input logic e0, input logic e1);
        vec_t v;
        v.v0 = v0; v.l0 = l0; v.v1 = v1; v.e0 = e0; v.e1 = e1;
        tbl.push_back(v);
    endtask

    logic        prev0, prev1;
    logic [15:0] pa0;

    initial begin
        rst = 1'b1;
        idle();
        r0_addr = 16'h0; r1_addr = 16'h0; r0_wdata = 33'h0; r1_wdata = 33'h0;

        // Reset: requests present but no grant while reset is high.
        @(negedge clk);
        r0_valid = 1'b1; r1_valid = 1'b1; #1;
        chk("rst_rdy0", r0_ready, 1'b0);
        chk("rst_rdy1", r1_ready, 1'b0);
        chk("rst_ram_en", ram_en, 1'b0);
        chk("rst_rsp0", r0_rsp_valid, 1'b0);
        chk("rst_rsp1", r1_rsp_valid, 1'b0);
        @(negedge clk);
        idle(); rst = 1'b0; #1;
        chk("post_rst_rsp0", r0_rsp_valid, 1'b0);
        chk("post_rst_rsp1", r1_rsp_valid, 1'b0);
        chk("post_rst_ram_we", ram_we, 1'b0);

        // Weighted round-robin: both valid -> r0 x4, r1, repeating.
        for (int k = 0; k < 10; k++) add(1'b1, 1'b0, 1'b1, (k % 5) != 4, (k % 5) == 4);
        // Loader idle clears credit; single requester always wins.
        add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Lock for 10 cycles starves r1; credit saturates, r1 wins on release.
        for (int k = 0; k < 10; k++) add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        // Lock arrives as credit reaches WEIGHT: lock still wins.
        for (int k = 0; k < 3; k++) add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        prev0 = 1'b0; prev1 = 1'b0; pa0 = 16'h0;
        foreach (tbl[i]) begin
            @(negedge clk);
            r0_valid = tbl[i].v0; r0_lock = tbl[i].l0; r0_we = 1'b0;
            r1_valid = tbl[i].v1; r1_we = 1'b0;
            r0_addr  = 16'h0040 + 16'(i);
            r1_addr  = 16'h0080 + 16'(i);
            #1;
            chk($sformatf("tbl%0d_rdy0", i), r0_ready, tbl[i].e0);
            chk($sformatf("tbl%0d_rdy1", i), r1_ready, tbl[i].e1);
            chk($sformatf("tbl%0d_ram_en", i), ram_en, tbl[i].e0 | tbl[i].e1);
            chk($sformatf("tbl%0d_rsp0", i), r0_rsp_valid, prev0);
            chk($sformatf("tbl%0d_rsp1", i), r1_rsp_valid, prev1);
            if (tbl[i].e0) chk($sformatf("tbl%0d_addr0", i), ram_addr, 16'h0040 + 16'(i));
            if (tbl[i].e1) chk($sformatf("tbl%0d_addr1", i), ram_addr, 16'h0080 + 16'(i));
            if (prev0) chk($sformatf("tbl%0d_data0", i), r0_rsp_data, init_val(pa0[7:0]));
            prev0 = tbl[i].e0; prev1 = tbl[i].e1; pa0 = 16'h0040 + 16'(i);
        end

        // Single r0 read of a preloaded cell.
        @(negedge clk);
        idle(); r0_valid = 1'b1; r0_addr = 16'h0010; #1;
        chk("rd_rdy0", r0_ready, 1'b1);
        chk("rd_rdy1", r1_ready, 1'b0);
        chk("rd_ram_we", ram_we, 1'b0);
        chk("rd_ram_addr", ram_addr, 16'h0010);
        @(negedge clk);
        idle(); #1;
        chk("rd_rsp0", r0_rsp_valid, 1'b1);
        chk("rd_data0", r0_rsp_data, 33'h1_2345_6789);
        chk("rd_rsp1", r1_rsp_valid, 1'b0);

        // Alternating reads r0@5, r1@6, r0@7: responses in order, no bubble.
        @(negedge clk);
        idle(); r0_valid = 1'b1; r0_addr = 16'h0005; #1;
        chk("alt0_rdy0", r0_ready, 1'b1);
        @(negedge clk);
        idle(); r1_valid = 1'b1; r1_addr = 16'h0006; #1;
        chk("alt1_rdy1", r1_ready, 1'b1);
        chk("alt1_rsp0", r0_rsp_valid, 1'b1);
        chk("alt1_rsp1", r1_rsp_valid, 1'b0);
        chk("alt1_data", r0_rsp_data, init_val(8'h05));
        @(negedge clk);
        idle(); r0_valid = 1'b1; r0_addr = 16'h0007; #1;
        chk("alt2_rsp0", r0_rsp_valid, 1'b0);
        chk("alt2_rsp1", r1_rsp_valid, 1'b1);
        chk("alt2_data", r1_rsp_data, init_val(8'h06));
        @(negedge clk);
        idle(); #1;
        chk("alt3_rsp0", r0_rsp_valid, 1'b1);
        chk("alt3_rsp1", r1_rsp_valid, 1'b0);
        chk("alt3_data", r0_rsp_data, init_val(8'h07));

        // Write 0xFF to 0x20, read it back next cycle; only the read responds.
        @(negedge clk);
        idle(); r0_valid = 1'b1; r0_we = 1'b1; r0_addr = 16'h0020; r0_wdata = 33'h0_0000_00FF; #1;
        chk("wr_ram_en", ram_en, 1'b1);
        chk("wr_ram_we", ram_we, 1'b1);
        chk("wr_wdata", ram_wdata, 33'h0_0000_00FF);
        @(negedge clk);
        r0_we = 1'b0; #1;
        chk("wr_rd_ram_we", ram_we, 1'b0);
        chk("wr_no_rsp", r0_rsp_valid, 1'b0);
        @(negedge clk);
        idle(); #1;
        chk("wr_rd_rsp0", r0_rsp_valid, 1'b1);
        chk("wr_rd_data", r0_rsp_data, 33'h0_0000_00FF);
        @(negedge clk);
        #1;
        chk("wr_rd_single", r0_rsp_valid, 1'b0);

        // Reset right after an r1 read transfer drops the response.
        @(negedge clk);
        idle(); r1_valid = 1'b1; r1_addr = 16'h0006; #1;
        chk("rr_rdy1", r1_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1; r1_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("rr_rsp1", r1_rsp_valid, 1'b0);
        chk("rr_rsp0", r0_rsp_valid, 1'b0);
        @(negedge clk);
        r0_valid = 1'b1; r1_valid = 1'b1; #1;
        chk("rr_rdy0_forced", r0_ready, 1'b0);
        chk("rr_rdy1_forced", r1_ready, 1'b0);
        chk("rr_rsp1_hold", r1_rsp_valid, 1'b0);
        @(negedge clk);
        idle(); rst = 1'b0; #1;
        chk("rr_rel_rsp0", r0_rsp_valid, 1'b0);
        chk("rr_rel_rsp1", r1_rsp_valid, 1'b0);
        chk("rr_rel_ram_en", ram_en, 1'b0);
        chk("rr_rel_ram_we", ram_we, 1'b0);
        // Credit restarts from 0: r0 x4 then r1.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            r0_valid = 1'b1; r1_valid = 1'b1; #1;
            chk($sformatf("rr_wrr%0d_rdy0", k), r0_ready, k != 4);
            chk($sformatf("rr_wrr%0d_rdy1", k), r1_ready, k == 4);
        end
        @(negedge clk);
        idle();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
